// File: rtl/register_bank.sv
`default_nettype none
// ============================================================================
// Module   : register_bank
// Brief    : DEPTH x WIDTH architectural register file with one byte-enabled
//            write port, NRD combinational read ports, an optional hardwired
//            zero register and a saturating committed-write counter.
//            Optional build macro REGISTER_BANK_BYPASS_EN enables same-cycle
//            write-first forwarding from the write port to the read ports.
// Revision : 1.0 - initial release
// ============================================================================
module register_bank #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr,
    input  logic [$clog2(DEPTH)-1:0]     wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic [WIDTH/8-1:0]           wr_be,
    input  logic [NRD*$clog2(DEPTH)-1:0] rd_addr,
    output logic [NRD*WIDTH-1:0]         rd_data,
    output logic [15:0]                  wr_count
);

    localparam int          c_AW      = $clog2(DEPTH);
    localparam int          c_NB      = WIDTH / 8;
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    // Storage is kept packed so the asynchronous clear is a single assignment.
    logic [DEPTH-1:0][WIDTH-1:0] r_mem;
    logic [15:0]                 r_wr_count;

    // A write aimed at the hardwired zero register is dropped entirely.
    logic w_zero_wr;
    logic w_commit;

    assign w_zero_wr = (ZERO_REG != 0) && (wr_addr == '0);
    assign w_commit  = wr && (|wr_be) && !w_zero_wr;

`ifdef REGISTER_BANK_BYPASS_EN
    // Forwarding is suppressed while reset is asserted so reads stay at zero.
    logic w_fwd_en;
    assign w_fwd_en = wr && rst;
`endif

    // Byte-masked write into the addressed word; reset clears all words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem <= '0;
        end else if (wr && !w_zero_wr) begin
            for (int b = 0; b < c_NB; b++) begin
                if (wr_be[b]) begin
                    r_mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Count committed writes, holding once the counter reaches its maximum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_count <= '0;
        end else if (w_commit && (r_wr_count != c_CNT_MAX)) begin
            r_wr_count <= r_wr_count + 16'd1;
        end
    end

    assign wr_count = r_wr_count;

    generate
        for (genvar k = 0; k < NRD; k++) begin : g_rd
            logic [c_AW-1:0]  w_addr;
            logic [WIDTH-1:0] w_word;

            assign w_addr = rd_addr[k*c_AW +: c_AW];

            // Look up the addressed word, optionally overlay the in-flight
            // write, and let the zero register override everything.
            always_comb begin
                w_word = r_mem[w_addr];
`ifdef REGISTER_BANK_BYPASS_EN
                if (w_fwd_en && (w_addr == wr_addr)) begin
                    for (int b = 0; b < c_NB; b++) begin
                        if (wr_be[b]) begin
                            w_word[8*b +: 8] = wr_data[8*b +: 8];
                        end
                    end
                end
`endif
                if ((ZERO_REG != 0) && (w_addr == '0)) begin
                    w_word = '0;
                end
            end

            assign rd_data[k*WIDTH +: WIDTH] = w_word;
        end
    endgenerate

endmodule
`default_nettype wire
